pipelined_csa_adder: RTL and testbench

Multi-cycle, throughput-one adder that splits a WIDTH-bit addition into SEG_WIDTH segments and resolves one segment per pipeline stage, with the inter-segment carry registered between stages. Each segment is a carry-select unit: both candidate sums are formed and the registered carry picks one. The block sits upstream of wide-datapath consumers in the arithmetic library, where the combinational carry-select adder cannot close timing at WIDTH ≥ 64. It uses a valid/ready handshake on both sides.

---
 rtl/arith_pkg.sv | 40 ++++
 rtl/pcsa_segment.sv | 24 ++
 rtl/pipelined_csa_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_csa_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library package: ceiling division, segment-count and
// segment-width derivation for the pipelined carry-select adder, and the
// {valid, ready} handshake-state encoding used by bench monitors.
package arith_pkg;

    // Handshake state as seen on one side of a valid/ready interface.
    typedef enum logic [1:0] {
        HS_IDLE  = 2'b00,   // no data offered, sink not ready
        HS_READY = 2'b01,   // sink ready, nothing offered (bubble)
        HS_STALL = 2'b10,   // data offered, sink holding off
        HS_XFER  = 2'b11    // transfer fires this cycle
    } hs_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Number of pipeline stages: one per segment.
    function automatic int pcsa_stages(input int width, input int seg_width);
        return ceil_div(width, seg_width);
    endfunction

    // Width of the last segment; narrower than seg_width when it does not divide width.
    function automatic int pcsa_last_seg_width(input int width, input int seg_width);
        return width - (pcsa_stages(width, seg_width) - 1) * seg_width;
    endfunction

    // Width of segment k (0-based).
    function automatic int pcsa_seg_width(input int width, input int seg_width, input int k);
        if (k == pcsa_stages(width, seg_width) - 1) begin
            return pcsa_last_seg_width(width, seg_width);
        end
        return seg_width;
    endfunction

    function automatic hs_state_t hs_state(input logic valid, input logic ready);
        return hs_state_t'({valid, ready});
    endfunction

endpackage

// File: rtl/pcsa_segment.sv
// One carry-select segment: both the +0 and +1 candidate sums are formed in
// parallel and the incoming carry selects one. Purely combinational.
module pcsa_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] sum0;
    logic [W:0] sum1;

    // Candidate sums at W+1 bits so the segment carry-out is the true MSB carry.
    always_comb begin
        sum0 = {1'b0, a} + {1'b0, b};
        sum1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    end

    assign {co, s} = ci ? sum1 : sum0;

endmodule

// File: rtl/pipelined_csa_adder.sv
// Throughput-one pipelined carry-select adder. A WIDTH-bit add is cut into
// SEG_WIDTH segments; stage k resolves segment k using the carry registered by
// stage k-1. Each stage carries the already-resolved low sum bits and only the
// operand bits still pending, so no register bit is dead.
// A single global advance stalls every stage together (bubbles are kept).
// Optional feature: define PIPELINED_CSA_ADDER_CIN_EN to add a carry-in port
// `cin`, sampled with a/b on transfer and used as the segment 0 carry-in.
module pipelined_csa_adder
    import arith_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPELINED_CSA_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             c
);

    localparam int STAGES = pcsa_stages(WIDTH, SEG_WIDTH);

    logic advance;
    logic cin0;

    // The whole pipe moves unless a valid result is being held by the sink.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

`ifdef PIPELINED_CSA_ADDER_CIN_EN
    assign cin0 = cin;
`else
    assign cin0 = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG_WIDTH;                          // first bit of this segment
        localparam int SW = pcsa_seg_width(WIDTH, SEG_WIDTH, k);    // this segment's width
        localparam int HI = LO + SW;                                // bits resolved after this stage
        localparam int PW = WIDTH - HI;                             // operand bits still pending

        logic          v_q;
        logic          cy_q;
        logic [HI-1:0] s_q;

        logic          v_d;
        logic          seg_ci;
        logic [SW-1:0] seg_a;
        logic [SW-1:0] seg_b;
        logic [SW-1:0] seg_s;
        logic          seg_co;
        logic [HI-1:0] s_d;

        if (k == 0) begin : g_head
            assign v_d    = in_valid;
            assign seg_ci = cin0;
            assign seg_a  = a[SW-1:0];
            assign seg_b  = b[SW-1:0];
            assign s_d    = seg_s;
        end else begin : g_body
            assign v_d    = g_stage[k-1].v_q;
            assign seg_ci = g_stage[k-1].cy_q;
            assign seg_a  = g_stage[k-1].g_pend.pa_q[SW-1:0];
            assign seg_b  = g_stage[k-1].g_pend.pb_q[SW-1:0];
            assign s_d    = {seg_s, g_stage[k-1].s_q};
        end

        pcsa_segment #(
            .W (SW)
        ) u_seg (
            .a  (seg_a),
            .b  (seg_b),
            .ci (seg_ci),
            .s  (seg_s),
            .co (seg_co)
        );

        // Valid, carry and resolved sum bits shift forward together on advance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                cy_q <= 1'b0;
                s_q  <= '0;
            end else if (advance) begin
                v_q  <= v_d;
                cy_q <= seg_co;
                s_q  <= s_d;
            end
        end

        if (PW > 0) begin : g_pend
            logic [PW-1:0] pa_q;
            logic [PW-1:0] pb_q;
            logic [PW-1:0] pa_d;
            logic [PW-1:0] pb_d;

            if (k == 0) begin : g_src_in
                assign pa_d = a[WIDTH-1:HI];
                assign pb_d = b[WIDTH-1:HI];
            end else begin : g_src_prev
                assign pa_d = g_stage[k-1].g_pend.pa_q[SW+PW-1:SW];
                assign pb_d = g_stage[k-1].g_pend.pb_q[SW+PW-1:SW];
            end

            // Unresolved upper operand bits ride along with their transaction.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (advance) begin
                    pa_q <= pa_d;
                    pb_q <= pb_d;
                end
            end
        end
    end

    // The last stage is the output register.
    assign out_valid = g_stage[STAGES-1].v_q;
    assign o         = g_stage[STAGES-1].s_q;
    assign c         = g_stage[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Directed bench for pipelined_csa_adder: a 32/8 instance (4 stages) with a
// scoreboard of hand-computed sums, plus a 30/8 instance for the partial last
// segment. Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_pipelined_csa_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, out_valid, out_ready, c;
    logic [31:0] a, b, o;
`ifdef PIPELINED_CSA_ADDER_CIN_EN
    logic        cin;
    logic        cin30;
`endif

    logic        in_valid30, in_ready30, out_valid30, out_ready30, c30;
    logic [29:0] a30, b30, o30;

    typedef struct packed {
        logic [32:0] exp;
        logic [31:0] stamp;
    } sb_t;

    sb_t         sb_q[$];
    logic [32:0] drv_exp;
    logic [31:0] cyc = 0;
    int          n_pop = 0;
    bit          lat_chk = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    // Hand-computed vectors: {carry, sum} for a + b at 32 bits.
    logic [31:0] tab_a [16] = '{
        32'h0000_0001, 32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF,
        32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
        32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hA5A5_A5A5,
        32'h0000_00FF, 32'h00FF_00FF, 32'h8080_8080, 32'hC000_0000};
    logic [31:0] tab_b [16] = '{
        32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
        32'h8000_0000, 32'h1111_1111, 32'hFFFF_FFFF, 32'h0000_0001,
        32'h0000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F1, 32'h5A5A_5A5A,
        32'h0000_00FF, 32'h0001_0001, 32'h8080_8080, 32'h4000_0000};
    logic [32:0] tab_e [16] = '{
        33'h0_0000_0003, 33'h0_0000_0100, 33'h0_0001_0000, 33'h0_0100_0000,
        33'h1_0000_0000, 33'h0_2345_6789, 33'h1_FFFF_FFFE, 33'h0_8000_0000,
        33'h0_DEAD_BEEF, 33'h0_FFFF_FFFF, 33'h1_0000_0000, 33'h0_FFFF_FFFF,
        33'h0_0000_01FE, 33'h0_0100_0100, 33'h1_0101_0100, 33'h1_0000_0000};

    always #5 clk = ~clk;

    pipelined_csa_adder #(
        .WIDTH     (32),
        .SEG_WIDTH (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef PIPELINED_CSA_ADDER_CIN_EN
        .cin       (cin),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .c         (c)
    );

    pipelined_csa_adder #(
        .WIDTH     (30),
        .SEG_WIDTH (8)
    ) u_dut30 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid30),
        .in_ready  (in_ready30),
        .a         (a30),
        .b         (b30),
`ifdef PIPELINED_CSA_ADDER_CIN_EN
        .cin       (cin30),
`endif
        .out_valid (out_valid30),
        .out_ready (out_ready30),
        .o         (o30),
        .c         (c30)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Retire results that hand off at the coming edge, then log the accepted input.
    always @(negedge clk) begin
        sb_t e;
        cyc = cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            check_val("sb_occupancy", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("result", {31'b0, c, o}, {31'b0, e.exp});
                if (lat_chk) check_val("latency", 64'(cyc - e.stamp), 64'd4);
                n_pop++;
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb_q.push_back('{exp: drv_exp, stamp: cyc});
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [32:0] ve);
        bit acc;
        int guard;
        a        = va;
        b        = vb;
        drv_exp  = ve;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = in_ready;
            guard++;
            @(posedge clk);
            #1;
        end
        check_val("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check_val("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run30(input logic [29:0] va, input logic [29:0] vb, input logic [30:0] ve);
        int n;
        a30        = va;
        b30        = vb;
        in_valid30 = 1'b1;
        @(posedge clk);
        #1;
        in_valid30 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid30 && n < 20);
        check_val("p30_latency", 64'(n), 64'd4);
        check_val("p30_sum", {33'b0, c30, o30}, {33'b0, ve});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int n0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        drv_exp     = '0;
        in_valid30  = 1'b0;
        out_ready30 = 1'b1;
        a30         = '0;
        b30         = '0;
`ifdef PIPELINED_CSA_ADDER_CIN_EN
        cin         = 1'b0;
        cin30       = 1'b0;
`endif

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_o", 64'(o), 64'd0);
        check_val("rst_c", 64'(c), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid30", 64'(out_valid30), 64'd0);
        @(posedge clk);
        #1;

        // Empty pipe with sink not ready still accepts
        out_ready = 1'b0;
        #1;
        check_val("bubble_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple
        send(32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        in_valid = 1'b0;
        drain();
`ifdef PIPELINED_CSA_ADDER_CIN_EN
        cin = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0000, 33'h1_0000_0000);
        in_valid = 1'b0;
        cin = 1'b0;
        drain();
`endif

        // Streaming, back to back
        n0 = n_pop;
        for (int i = 0; i < 16; i++) send(tab_a[i], tab_b[i], tab_e[i]);
        in_valid = 1'b0;
        drain();
        check_val("stream_count", 64'(n_pop - n0), 64'd16);

        // Backpressure with a full pipe
        lat_chk = 1'b0;
        n0 = n_pop;
        for (int i = 0; i < 4; i++) send(tab_a[i], tab_b[i], tab_e[i]);
        out_ready = 1'b0;
        a         = tab_a[4];
        b         = tab_b[4];
        drv_exp   = tab_e[4];
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
            check_val("stall_out_valid", 64'(out_valid), 64'd1);
            check_val("stall_hold", {31'b0, c, o}, {31'b0, tab_e[0]});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(tab_a[i], tab_b[i], tab_e[i]);
        in_valid = 1'b0;
        drain();
        check_val("bp_count", 64'(n_pop - n0), 64'd8);
        lat_chk = 1'b1;

        // Mid-stream reset with the pipe full
        for (int i = 9; i < 13; i++) send(tab_a[i], tab_b[i], tab_e[i]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mrst_out_valid", 64'(out_valid), 64'd0);
        check_val("mrst_o", {31'b0, c, o}, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("mrst_no_stale", 64'(out_valid), 64'd0);
        end
        check_val("mrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        n0 = n_pop;
        send(tab_a[13], tab_b[13], tab_e[13]);
        in_valid = 1'b0;
        drain();
        check_val("mrst_count", 64'(n_pop - n0), 64'd1);

        // Partial last segment (30 bits: 8+8+8+6)
        run30(30'h3FFF_FFFF, 30'h0000_0001, 31'h4000_0000);
        run30(30'h2000_0000, 30'h2000_0000, 31'h4000_0000);
        run30(30'h1FFF_FFFF, 30'h0000_0001, 31'h2000_0000);
        run30(30'h0123_4567, 30'h0011_1111, 31'h0134_5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
